// File: rtl/serial_rx_buffer.sv
// serial_rx_buffer
//   Asynchronous serial receiver (start bit, DATA_BITS data bits LSB first,
//   optional parity bit, one stop bit) feeding a first-word-fall-through
//   receive FIFO with sticky error reporting.
//
// Ports
//   CLK            single clock, rising edge
//   RESET          synchronous, active-high reset
//   IN_SERIAL_RX   asynchronous serial line, idle high
//   IN_READY       consumer takes the head entry this cycle (ignored when empty)
//   IN_CLR_ERR     one-cycle pulse clearing the sticky error flags
//   OUT_DATA       FIFO head byte, zero-extended above DATA_BITS
//   OUT_VALID      FIFO non-empty
//   OUT_COUNT      FIFO occupancy, 0..FIFO_DEPTH
//   OUT_FRAME_ERR  sticky: stop bit sampled low
//   OUT_PARITY_ERR sticky: parity mismatch
//   OUT_OVERRUN    sticky: completed byte dropped because the FIFO was full
module serial_rx_buffer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          IN_SERIAL_RX,
  input  logic                          IN_READY,
  input  logic                          IN_CLR_ERR,
  output logic [7:0]                    OUT_DATA,
  output logic                          OUT_VALID,
  output logic [$clog2(FIFO_DEPTH):0]   OUT_COUNT,
  output logic                          OUT_FRAME_ERR,
  output logic                          OUT_PARITY_ERR,
  output logic                          OUT_OVERRUN
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Parity bit the transmitter should have sent for this data word.
  function automatic logic expected_parity(input logic [DATA_BITS-1:0] data,
                                           input logic                 odd_mode);
    if (odd_mode) begin
      expected_parity = ~(^data);
    end else begin
      expected_parity = ^data;
    end
  endfunction

  logic                 sync1_r, sync2_r, rx_s;
  state_t               state_r, state_next_s;
  logic [TW-1:0]        timer_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_bad_r;
  logic                 sample_s, push_req_s, frame_evt_s, par_evt_s;

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
  logic [CW-1:0]        count_r, count_next_s;
  logic                 out_valid_r;
  logic [7:0]           data_r, data_next_s;
  logic [DATA_BITS-1:0] head_s;
  logic                 pop_s, full_s, push_s, overrun_evt_s;
  logic                 frame_err_r, parity_err_r, overrun_r;

  assign rx_s = sync2_r;

  // Two-flop synchroniser on the asynchronous serial line (idles high).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= IN_SERIAL_RX;
      sync2_r <= sync1_r;
    end
  end

  // Receiver state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Receiver next-state and frame-completion events.
  always_comb begin
    state_next_s = state_r;
    sample_s     = 1'b0;
    push_req_s   = 1'b0;
    frame_evt_s  = 1'b0;
    par_evt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) state_next_s = ST_START;
        else       state_next_s = ST_IDLE;
      end
      ST_START: begin
        // Re-check the start bit at its middle; a high line here was a glitch.
        if (timer_r == T_HALF) begin
          sample_s = 1'b1;
          if (rx_s) state_next_s = ST_IDLE;
          else      state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (timer_r == T_FULL) begin
          sample_s = 1'b1;
          if (bit_cnt_r == B_LAST) begin
            if (PARITY != 0) state_next_s = ST_PARITY;
            else             state_next_s = ST_STOP;
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (timer_r == T_FULL) begin
          sample_s     = 1'b1;
          state_next_s = ST_STOP;
        end else begin
          state_next_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (timer_r == T_FULL) begin
          sample_s     = 1'b1;
          state_next_s = ST_IDLE;
          // A framing error takes precedence over a parity error.
          if (!rx_s)          frame_evt_s = 1'b1;
          else if (par_bad_r) par_evt_s   = 1'b1;
          else                push_req_s  = 1'b1;
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Bit timer, data bit counter, shift register and parity check.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      timer_r   <= '0;
      bit_cnt_r <= '0;
      shift_r   <= '0;
      par_bad_r <= 1'b0;
    end else begin
      // Timer restarts on every sample so the next sample lands mid-bit.
      if (state_r == ST_IDLE || sample_s) timer_r <= '0;
      else                                timer_r <= timer_r + TW'(1);
      if (state_r == ST_START) begin
        bit_cnt_r <= '0;
        par_bad_r <= 1'b0;
      end else if (state_r == ST_DATA && sample_s) begin
        bit_cnt_r <= bit_cnt_r + BW'(1);
        shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
      end else if (state_r == ST_PARITY && sample_s) begin
        par_bad_r <= (rx_s != expected_parity(shift_r, PARITY == 1));
      end
    end
  end

  // FIFO control: pop/push arbitration and next head value for the output register.
  always_comb begin
    pop_s         = out_valid_r && IN_READY;
    full_s        = (count_r == C_FULL);
    push_s        = push_req_s && (!full_s || pop_s);
    overrun_evt_s = push_req_s && full_s && !pop_s;
    if (push_s) wr_ptr_next_s = wr_ptr_r + AW'(1);
    else        wr_ptr_next_s = wr_ptr_r;
    if (pop_s)  rd_ptr_next_s = rd_ptr_r + AW'(1);
    else        rd_ptr_next_s = rd_ptr_r;
    if (push_s && !pop_s)      count_next_s = count_r + CW'(1);
    else if (!push_s && pop_s) count_next_s = count_r - CW'(1);
    else                       count_next_s = count_r;
    // The entry being written this edge may become the new head.
    if (push_s && (wr_ptr_r == rd_ptr_next_s)) head_s = shift_r;
    else                                       head_s = mem_r[rd_ptr_next_s];
    if (count_next_s == '0) data_next_s = 8'h00;
    else                    data_next_s = 8'(head_s);
  end

  // FIFO storage; contents need no reset because the pointers gate their use.
  always_ff @(posedge CLK) begin
    if (!RESET && push_s) mem_r[wr_ptr_r] <= shift_r;
  end

  // FIFO pointers, occupancy, registered head and sticky error flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      out_valid_r  <= 1'b0;
      data_r       <= 8'h00;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      out_valid_r <= (count_next_s != '0);
      data_r      <= data_next_s;
      // A new error event wins over a coincident clear.
      if (frame_evt_s)     frame_err_r  <= 1'b1;
      else if (IN_CLR_ERR) frame_err_r  <= 1'b0;
      if (par_evt_s)       parity_err_r <= 1'b1;
      else if (IN_CLR_ERR) parity_err_r <= 1'b0;
      if (overrun_evt_s)   overrun_r    <= 1'b1;
      else if (IN_CLR_ERR) overrun_r    <= 1'b0;
    end
  end

  assign OUT_DATA       = data_r;
  assign OUT_VALID      = out_valid_r;
  assign OUT_COUNT      = count_r;
  assign OUT_FRAME_ERR  = frame_err_r;
  assign OUT_PARITY_ERR = parity_err_r;
  assign OUT_OVERRUN    = overrun_r;

endmodule

// File: tb/tb_serial_rx_buffer.sv
// Bench for serial_rx_buffer: two instances (no parity and even parity),
// a queue-based reference model of the receive FIFO and sticky flags.
module tb_serial_rx_buffer;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b1;
  logic sel = 1'b0;
  logic rdy = 1'b0;
  logic clr = 1'b0;
  wire  rx0 = sel ? 1'b1 : line;
  wire  rx1 = sel ? line : 1'b1;

  logic [7:0] data0, data1;
  logic       valid0, valid1, fe0, fe1, pe0, pe1, ov0, ov1;
  logic [2:0] count0, count1;

  serial_rx_buffer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(DEPTH)) dut0 (
    .CLK(clk), .RESET(rst), .IN_SERIAL_RX(rx0), .IN_READY(rdy), .IN_CLR_ERR(clr),
    .OUT_DATA(data0), .OUT_VALID(valid0), .OUT_COUNT(count0),
    .OUT_FRAME_ERR(fe0), .OUT_PARITY_ERR(pe0), .OUT_OVERRUN(ov0));

  serial_rx_buffer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(DEPTH)) dut1 (
    .CLK(clk), .RESET(rst), .IN_SERIAL_RX(rx1), .IN_READY(rdy), .IN_CLR_ERR(clr),
    .OUT_DATA(data1), .OUT_VALID(valid1), .OUT_COUNT(count1),
    .OUT_FRAME_ERR(fe1), .OUT_PARITY_ERR(pe1), .OUT_OVERRUN(ov1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents and sticky flags of dut0.
  logic [7:0] q[$];
  logic m_fe, m_pe, m_ov;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; line = 1'b1; rdy = 1'b0; clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    q.delete(); m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
  endtask

  // Drives one whole frame; par < 0 means no parity bit. pop_at / clr_at give
  // the cycle of the frame in which IN_READY / IN_CLR_ERR is pulsed (-1: never).
  task automatic send_frame(input logic [7:0] d, input int par, input logic stop,
                            input int pop_at, input int clr_at);
    logic [11:0] b;
    int n;
    b = 12'hFFF;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1 + i] = d[i];
    n = 9;
    if (par >= 0) begin b[n] = par[0]; n++; end
    b[n] = stop; n++;
    for (int c = 0; c < n * CPB; c++) begin
      line = b[c / CPB];
      rdy  = (c == pop_at);
      clr  = (c == clr_at);
      tick();
    end
    line = 1'b1; rdy = 1'b0; clr = 1'b0;
    repeat (4) tick();
  endtask

  // Frame outcome from the receiver rules (pop on the same edge served first).
  task automatic model_rx(input logic [7:0] d, input logic stop, input logic par_ok,
                          input logic same_edge_pop);
    if (same_edge_pop && q.size() > 0) void'(q.pop_front());
    if (!stop)                   m_fe = 1'b1;
    else if (!par_ok)            m_pe = 1'b1;
    else if (q.size() < DEPTH)   q.push_back(d);
    else                         m_ov = 1'b1;
  endtask

  task automatic do_pop();
    rdy = 1'b1; tick(); rdy = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (valid0 !== 1'b0 || count0 !== 3'd0) begin errors++;
      $display("FAIL reset_fifo: got valid=%0b count=%0d expected 0 0", valid0, count0); end
    checks++; if (data0 !== 8'h00) begin errors++;
      $display("FAIL reset_data: got %02h expected 00", data0); end
    checks++; if ({fe0, pe0, ov0} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: got %03b expected 000", {fe0, pe0, ov0}); end
  endtask

  task automatic test_single();
    apply_reset();
    send_frame(8'h55, -1, 1'b1, -1, -1); model_rx(8'h55, 1'b1, 1'b1, 1'b0);
    checks++; if (valid0 !== 1'b1 || data0 !== 8'h55 || count0 !== 3'd1) begin errors++;
      $display("FAIL single_rx: got v=%0b d=%02h c=%0d expected 1 55 1", valid0, data0, count0); end
    checks++; if ({fe0, pe0, ov0} !== 3'b000) begin errors++;
      $display("FAIL single_flags: got %03b expected 000", {fe0, pe0, ov0}); end
    do_pop();
    checks++; if (count0 !== 3'd0 || valid0 !== 1'b0) begin errors++;
      $display("FAIL single_pop: got c=%0d v=%0b expected 0 0", count0, valid0); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), -1, 1'b1, -1, -1); model_rx(8'(i), 1'b1, 1'b1, 1'b0);
    end
    checks++; if (count0 !== 3'd4 || ov0 !== 1'b1) begin errors++;
      $display("FAIL overrun_full: got c=%0d ov=%0b expected 4 1", count0, ov0); end
    for (int i = 0; i < 4; i++) begin
      exp = q[0];
      checks++; if (data0 !== exp || valid0 !== 1'b1) begin errors++;
        $display("FAIL overrun_order: got %02h expected %02h", data0, exp); end
      do_pop();
    end
    checks++; if (count0 !== 3'd0) begin errors++;
      $display("FAIL overrun_drain: got %0d expected 0", count0); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), -1, 1'b1, -1, -1); model_rx(8'(i), 1'b1, 1'b1, 1'b0);
    end
    // The stop bit is sampled at cycle 155 of the frame; pulse IN_READY for that edge.
    send_frame(8'h05, -1, 1'b1, 154, -1); model_rx(8'h05, 1'b1, 1'b1, 1'b1);
    checks++; if (count0 !== 3'd4 || ov0 !== 1'b0) begin errors++;
      $display("FAIL fullpop_count: got c=%0d ov=%0b expected 4 0", count0, ov0); end
    for (int i = 0; i < 4; i++) begin
      exp = q[0];
      checks++; if (data0 !== exp) begin errors++;
        $display("FAIL fullpop_order: got %02h expected %02h", data0, exp); end
      do_pop();
    end
  endtask

  task automatic test_frame_err();
    apply_reset();
    send_frame(8'h3C, -1, 1'b0, -1, -1); model_rx(8'h3C, 1'b0, 1'b1, 1'b0);
    checks++; if (fe0 !== 1'b1 || count0 !== 3'd0) begin errors++;
      $display("FAIL frame_err: got fe=%0b c=%0d expected 1 0", fe0, count0); end
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (fe0 !== 1'b0) begin errors++;
      $display("FAIL frame_clr: got %0b expected 0", fe0); end
    // Clear pulse on the very edge the bad stop bit is sampled: flag must stay set.
    send_frame(8'h3C, -1, 1'b0, -1, 154);
    checks++; if (fe0 !== 1'b1) begin errors++;
      $display("FAIL frame_clr_coincident: got %0b expected 1", fe0); end
  endtask

  task automatic test_parity();
    apply_reset();
    sel = 1'b1;
    send_frame(8'hA3, 1, 1'b1, -1, -1);
    checks++; if (pe1 !== 1'b1 || count1 !== 3'd0 || fe1 !== 1'b0) begin errors++;
      $display("FAIL parity_bad: got pe=%0b c=%0d fe=%0b expected 1 0 0", pe1, count1, fe1); end
    send_frame(8'hA3, 0, 1'b1, -1, -1);
    checks++; if (count1 !== 3'd1 || data1 !== 8'hA3 || valid1 !== 1'b1) begin errors++;
      $display("FAIL parity_ok: got c=%0d d=%02h expected 1 a3", count1, data1); end
    sel = 1'b0;
  endtask

  task automatic test_glitch_reset();
    logic [7:0] junk;
    logic [9:0] b;
    apply_reset();
    line = 1'b0; repeat (4) tick(); line = 1'b1;
    repeat (40) tick();
    checks++; if (count0 !== 3'd0 || {fe0, pe0, ov0} !== 3'b000) begin errors++;
      $display("FAIL glitch: got c=%0d flags=%03b expected 0 000", count0, {fe0, pe0, ov0}); end
    junk = 8'($urandom);
    b = {1'b1, junk, 1'b0};
    for (int c = 0; c < 5 * CPB + 8; c++) begin line = b[c / CPB]; tick(); end
    rst = 1'b1; line = 1'b1; tick(); tick(); rst = 1'b0;
    repeat (20) tick();
    send_frame(8'h7E, -1, 1'b1, -1, -1);
    checks++; if (count0 !== 3'd1 || data0 !== 8'h7E || {fe0, pe0, ov0} !== 3'b000) begin errors++;
      $display("FAIL reset_midframe: got c=%0d d=%02h flags=%03b expected 1 7e 000",
               count0, data0, {fe0, pe0, ov0}); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic stop;
    int npop;
    apply_reset();
    for (int it = 0; it < 30; it++) begin
      d = 8'($urandom);
      stop = ($urandom_range(9) != 0);
      send_frame(d, -1, stop, -1, -1); model_rx(d, stop, 1'b1, 1'b0);
      checks++; if (count0 !== 3'(q.size()) || valid0 !== (q.size() != 0)) begin errors++;
        $display("FAIL rand_count[%0d]: got %0d expected %0d", it, count0, q.size()); end
      if (q.size() != 0) begin
        checks++; if (data0 !== q[0]) begin errors++;
          $display("FAIL rand_data[%0d]: got %02h expected %02h", it, data0, q[0]); end
      end
      checks++; if ({fe0, pe0, ov0} !== {m_fe, m_pe, m_ov}) begin errors++;
        $display("FAIL rand_flags[%0d]: got %03b expected %03b", it, {fe0, pe0, ov0}, {m_fe, m_pe, m_ov}); end
      npop = $urandom_range(2);
      for (int p = 0; p < npop; p++) do_pop();
      if ($urandom_range(3) == 0) begin
        clr = 1'b1; tick(); clr = 1'b0;
        m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_full_pop();
    test_frame_err();
    test_parity();
    test_glitch_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
